krake_intercon: RTL and testbench

Parametrised 8-bit Wishbone-style interconnect between the external bus master (`krake_bus`) and N_SLAVES peripheral slaves (channel ports, clock generators). It decodes the upper address bits into a one-hot slave strobe and holds the selected slave's strobe until that slave acknowledges. It returns registered read data with a single-cycle ack, and raises an error response for unmapped addresses or slaves that never acknowledge. It replaces the fixed 12-slave combinational decode/mux in the core.

---
 rtl/krake_pkg.sv | 31 +++
 rtl/krake_intercon_if.sv | 43 ++++
 rtl/krake_watchdog.sv | 33 +++
 rtl/krake_intercon.sv | 142 ++++++++++++++
 tb/tb_krake_intercon.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/krake_pkg.sv
// krake_pkg: definitions shared by the krake interconnect.
//   - state_e   : interconnect transaction states (IDLE/WAIT/DONE)
//   - *_BASE    : base addresses of the attached slaves; the slave index
//                 is the upper nibble of the master address
//   - *_W_DEF   : default master / slave-local address widths
package krake_pkg;

    localparam int ADR_W_DEF = 8;
    localparam int SUB_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Channel ports occupy slaves 0..7, clock generators slaves 8..11.
    localparam logic [7:0] CH1_BASE  = 8'h00;
    localparam logic [7:0] CH2_BASE  = 8'h10;
    localparam logic [7:0] CH3_BASE  = 8'h20;
    localparam logic [7:0] CH4_BASE  = 8'h30;
    localparam logic [7:0] CH5_BASE  = 8'h40;
    localparam logic [7:0] CH6_BASE  = 8'h50;
    localparam logic [7:0] CH7_BASE  = 8'h60;
    localparam logic [7:0] CH8_BASE  = 8'h70;
    localparam logic [7:0] CLKA_BASE = 8'h80;
    localparam logic [7:0] CLKB_BASE = 8'h90;
    localparam logic [7:0] CLKC_BASE = 8'hA0;
    localparam logic [7:0] CLKD_BASE = 8'hB0;

endpackage

// File: rtl/krake_intercon_if.sv
// krake_intercon_if: bus signals between the master, the interconnect and
// the peripheral slaves.
//   master-side : stb_i, we_i, adr_i, dat_i (requests)
//                 dat_o, ack_o, err_o, busy_o (responses)
//   slave-side  : s_stb_o, s_we_o, s_adr_o, s_dat_o (to slaves)
//                 s_dat_i (8 bits per slave, slave k at [8k+7:8k]), s_ack_i
// Modports:
//   slave  : the interconnect's view (it is the slave of the master bus)
//   master : the bus master / slave-array view driving the interconnect
interface krake_intercon_if
    import krake_pkg::*;
#(
    parameter int N_SLAVES = 12,
    parameter int ADR_W    = ADR_W_DEF,
    parameter int SUB_W    = SUB_W_DEF
);

    logic                  stb_i;
    logic                  we_i;
    logic [ADR_W-1:0]      adr_i;
    logic [7:0]            dat_i;
    logic [7:0]            dat_o;
    logic                  ack_o;
    logic                  err_o;
    logic                  busy_o;
    logic [N_SLAVES-1:0]   s_stb_o;
    logic                  s_we_o;
    logic [SUB_W-1:0]      s_adr_o;
    logic [7:0]            s_dat_o;
    logic [8*N_SLAVES-1:0] s_dat_i;
    logic [N_SLAVES-1:0]   s_ack_i;

    modport slave (
        input  stb_i, we_i, adr_i, dat_i, s_dat_i, s_ack_i,
        output dat_o, ack_o, err_o, busy_o, s_stb_o, s_we_o, s_adr_o, s_dat_o
    );

    modport master (
        output stb_i, we_i, adr_i, dat_i, s_dat_i, s_ack_i,
        input  dat_o, ack_o, err_o, busy_o, s_stb_o, s_we_o, s_adr_o, s_dat_o
    );

endinterface

// File: rtl/krake_watchdog.sv
// krake_watchdog: counts cycles spent waiting for a slave acknowledge.
//   clk_i     : system clock
//   rst_i     : synchronous active-high reset
//   clr_i     : clear the count (held while not waiting)
//   en_i      : count this cycle
//   expired_o : current cycle is the last one allowed (TIMEOUT-th)
// The count saturates at TIMEOUT rather than wrapping.
module krake_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != CNT_W'(TIMEOUT))) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // cnt_q counts completed wait cycles, so TIMEOUT-1 marks the final one.
    assign expired_o = (cnt_q >= CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/krake_intercon.sv
// krake_intercon: master-to-N_SLAVES interconnect.
//   clk_i : system clock (rising edge)
//   rst_i : synchronous active-high reset
//   bus   : krake_intercon_if.slave (master request/response and slave
//           strobe/ack/data signals)
// Decodes adr_i[ADR_W-1:SUB_W] into a one-hot slave strobe held until that
// slave acks; returns registered read data with a one-cycle ack_o, or a
// one-cycle err_o for unmapped addresses.
// Build option: define KRAKE_INTERCON_TIMEOUT_EN to add a watchdog that
// raises err_o when the selected slave does not ack within TIMEOUT cycles.
module krake_intercon
    import krake_pkg::*;
#(
    parameter int N_SLAVES = 12,
    parameter int ADR_W    = ADR_W_DEF,
    parameter int SUB_W    = SUB_W_DEF,
    parameter int TIMEOUT  = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    krake_intercon_if.slave    bus
);

    localparam int IDX_W = ADR_W - SUB_W;

    if (N_SLAVES < 1 || N_SLAVES > 2 ** IDX_W || TIMEOUT < 1) begin : g_bad_params
        $error("krake_intercon: illegal N_SLAVES/ADR_W/SUB_W/TIMEOUT combination");
    end

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [N_SLAVES-1:0] s_stb_q, s_stb_d;
    logic                s_we_q, s_we_d;
    logic [SUB_W-1:0]    s_adr_q, s_adr_d;
    logic [7:0]          s_dat_q, s_dat_d;
    logic [7:0]          dat_q, dat_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic [IDX_W-1:0]    adr_idx;
    logic                timeout;

    assign adr_idx = bus.adr_i[ADR_W-1:SUB_W];

`ifdef KRAKE_INTERCON_TIMEOUT_EN
    // Held clear outside WAIT, so every WAIT entry starts from zero.
    krake_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (state_q != ST_WAIT),
        .en_i      (state_q == ST_WAIT),
        .expired_o (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d = state_q;
        idx_d   = idx_q;
        s_stb_d = s_stb_q;
        s_we_d  = s_we_q;
        s_adr_d = s_adr_q;
        s_dat_d = s_dat_q;
        dat_d   = dat_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.stb_i) begin
                    idx_d   = adr_idx;
                    s_we_d  = bus.we_i;
                    s_adr_d = bus.adr_i[SUB_W-1:0];
                    s_dat_d = bus.dat_i;
                    if (32'(adr_idx) < N_SLAVES) begin
                        s_stb_d = N_SLAVES'(1) << adr_idx;
                        state_d = ST_WAIT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_WAIT: begin
                // Ack is tested before timeout: an ack on the last allowed
                // cycle still completes normally.
                if (bus.s_ack_i[idx_q]) begin
                    dat_d   = bus.s_dat_i[8*int'(idx_q) +: 8];
                    ack_d   = 1'b1;
                    s_stb_d = '0;
                    state_d = ST_DONE;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    s_stb_d = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            s_stb_q <= '0;
            s_we_q  <= 1'b0;
            s_adr_q <= '0;
            s_dat_q <= '0;
            dat_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            s_stb_q <= s_stb_d;
            s_we_q  <= s_we_d;
            s_adr_q <= s_adr_d;
            s_dat_q <= s_dat_d;
            dat_q   <= dat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign bus.dat_o   = dat_q;
    assign bus.ack_o   = ack_q;
    assign bus.err_o   = err_q;
    assign bus.busy_o  = (state_q != ST_IDLE);
    assign bus.s_stb_o = s_stb_q;
    assign bus.s_we_o  = s_we_q;
    assign bus.s_adr_o = s_adr_q;
    assign bus.s_dat_o = s_dat_q;

endmodule

// File: tb/tb_krake_intercon.sv
// tb_krake_intercon: directed bench for krake_intercon with a response
// scoreboard. Expected responses are queued when a request is issued and
// checked by a monitor when ack_o/err_o appears; cycle-exact checks are made
// inline. Works with or without KRAKE_INTERCON_TIMEOUT_EN.
module tb_krake_intercon;

    localparam int N_SLAVES = 12;
    localparam int ADR_W    = 8;
    localparam int SUB_W    = 4;
    localparam int TIMEOUT  = 16;

    typedef struct {
        logic       is_err;
        logic       chk_dat;
        logic [7:0] dat;
    } resp_t;

    logic  clk_i = 1'b0;
    logic  rst_i = 1'b1;
    resp_t sb[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk_i = ~clk_i;

    krake_intercon_if #(
        .N_SLAVES (N_SLAVES),
        .ADR_W    (ADR_W),
        .SUB_W    (SUB_W)
    ) bus ();

    krake_intercon #(
        .N_SLAVES (N_SLAVES),
        .ADR_W    (ADR_W),
        .SUB_W    (SUB_W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic req(input logic we, input logic [7:0] adr, input logic [7:0] dat);
        bus.stb_i = 1'b1;
        bus.we_i  = we;
        bus.adr_i = adr;
        bus.dat_i = dat;
    endtask

    // Response monitor: every ack_o/err_o pulse must match the oldest
    // outstanding expectation.
    always @(negedge clk_i) begin
        resp_t e;
        if (!rst_i && (bus.ack_o || bus.err_o)) begin
            if (sb.size() == 0) begin
                check("resp_unexpected", {30'd0, bus.ack_o, bus.err_o}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("resp_err", bus.err_o, e.is_err);
                check("resp_ack", bus.ack_o, !e.is_err);
                if (e.chk_dat) check("resp_dat", bus.dat_o, e.dat);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int seen_err;
        bus.stb_i   = 1'b0;
        bus.we_i    = 1'b0;
        bus.adr_i   = '0;
        bus.dat_i   = '0;
        bus.s_dat_i = '0;
        bus.s_ack_i = '0;

        // Reset state
        repeat (3) step();
        check("rst_busy",  bus.busy_o,  0);
        check("rst_ack",   bus.ack_o,   0);
        check("rst_err",   bus.err_o,   0);
        check("rst_s_stb", bus.s_stb_o, 0);
        check("rst_dat_o", bus.dat_o,   0);
        check("rst_s_adr", bus.s_adr_o, 0);
        check("rst_s_dat", bus.s_dat_o, 0);
        check("rst_s_we",  bus.s_we_o,  0);
        rst_i = 1'b0;

        // Write to slave 3, immediate ack
        req(1'b1, 8'h35, 8'hA5);
        sb.push_back('{is_err: 1'b0, chk_dat: 1'b0, dat: 8'h00});
        step();
        bus.stb_i      = 1'b0;
        bus.s_ack_i[3] = 1'b1;
        check("wr_s_stb", bus.s_stb_o, 12'h008);
        check("wr_s_adr", bus.s_adr_o, 4'h5);
        check("wr_s_dat", bus.s_dat_o, 8'hA5);
        check("wr_s_we",  bus.s_we_o,  1);
        check("wr_busy",  bus.busy_o,  1);
        check("wr_ack_early", bus.ack_o, 0);
        step();
        bus.s_ack_i = '0;
        check("wr_ack",   bus.ack_o,   1);
        check("wr_err",   bus.err_o,   0);
        check("wr_s_stb_drop", bus.s_stb_o, 0);
        step();
        check("wr_idle",  bus.busy_o,  0);
        check("wr_ack_pulse", bus.ack_o, 0);

        // Read from slave 11, ack after 4 cycles; stray ack and stb while busy
        bus.s_dat_i[8*11 +: 8] = 8'h5C;
        req(1'b0, 8'hB2, 8'h00);
        sb.push_back('{is_err: 1'b0, chk_dat: 1'b1, dat: 8'h5C});
        step();
        bus.stb_i = 1'b0;
        check("rd_s_stb_t1", bus.s_stb_o, 12'h800);
        check("rd_s_adr",    bus.s_adr_o, 4'h2);
        check("rd_s_we",     bus.s_we_o,  0);
        bus.s_ack_i[4] = 1'b1;
        req(1'b1, 8'h45, 8'h77);
        step();
        bus.s_ack_i = '0;
        check("rd_s_stb_t2", bus.s_stb_o, 12'h800);
        check("rd_stray_ack", bus.ack_o,  0);
        check("rd_busy_t2",  bus.busy_o,  1);
        step();
        bus.stb_i = 1'b0;
        check("rd_s_stb_t3", bus.s_stb_o, 12'h800);
        check("rd_s_adr_held", bus.s_adr_o, 4'h2);
        check("rd_s_we_held",  bus.s_we_o,  0);
        step();
        check("rd_s_stb_t4", bus.s_stb_o, 12'h800);
        step();
        check("rd_s_stb_t5", bus.s_stb_o, 12'h800);
        check("rd_ack_t5",   bus.ack_o,   0);
        bus.s_ack_i[11] = 1'b1;
        step();
        bus.s_ack_i = '0;
        check("rd_ack_t6",   bus.ack_o,   1);
        check("rd_dat_t6",   bus.dat_o,   8'h5C);
        check("rd_s_stb_t6", bus.s_stb_o, 0);
        step();
        check("rd_idle",     bus.busy_o,  0);

        // Decode error
        req(1'b0, 8'hE0, 8'h00);
        sb.push_back('{is_err: 1'b1, chk_dat: 1'b0, dat: 8'h00});
        step();
        bus.stb_i = 1'b0;
        check("dec_err",   bus.err_o,   1);
        check("dec_ack",   bus.ack_o,   0);
        check("dec_s_stb", bus.s_stb_o, 0);
        check("dec_busy",  bus.busy_o,  1);
        step();
        check("dec_idle",  bus.busy_o,  0);
        check("dec_err_pulse", bus.err_o, 0);

        bus.s_dat_i[8*2 +: 8] = 8'h9E;
`ifdef KRAKE_INTERCON_TIMEOUT_EN
        // Timeout: no ack, err_o at T+1+TIMEOUT
        req(1'b0, 8'h20, 8'h00);
        sb.push_back('{is_err: 1'b1, chk_dat: 1'b0, dat: 8'h00});
        step();
        bus.stb_i = 1'b0;
        for (int i = 1; i <= TIMEOUT; i++) begin
            check("to_s_stb_wait", bus.s_stb_o, 12'h004);
            check("to_err_early",  bus.err_o,   0);
            step();
        end
        check("to_err",   bus.err_o,   1);
        check("to_s_stb", bus.s_stb_o, 0);
        step();
        check("to_idle",  bus.busy_o,  0);

        // Ack on the final WAIT cycle beats the timeout
        req(1'b0, 8'h27, 8'h00);
        sb.push_back('{is_err: 1'b0, chk_dat: 1'b1, dat: 8'h9E});
        step();
        bus.stb_i = 1'b0;
        repeat (TIMEOUT - 1) step();
        bus.s_ack_i[2] = 1'b1;
        step();
        bus.s_ack_i = '0;
        check("to_last_ack", bus.ack_o, 1);
        check("to_last_err", bus.err_o, 0);
        step();
        check("to_last_idle", bus.busy_o, 0);
`else
        // No watchdog: WAIT persists, a late ack completes
        req(1'b0, 8'h27, 8'h00);
        sb.push_back('{is_err: 1'b0, chk_dat: 1'b1, dat: 8'h9E});
        step();
        bus.stb_i = 1'b0;
        seen_err = 0;
        repeat (100) begin
            if (bus.err_o) seen_err++;
            step();
        end
        check("nto_no_err", seen_err,     0);
        check("nto_busy",   bus.busy_o,   1);
        check("nto_s_stb",  bus.s_stb_o,  12'h004);
        bus.s_ack_i[2] = 1'b1;
        step();
        bus.s_ack_i = '0;
        check("nto_late_ack", bus.ack_o,  1);
        step();
        check("nto_idle",   bus.busy_o,   0);
`endif

        // Reset in WAIT abandons the transaction (no response expected)
        req(1'b1, 8'h70, 8'h11);
        step();
        bus.stb_i = 1'b0;
        check("rw_s_stb", bus.s_stb_o, 12'h080);
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("rw_busy",  bus.busy_o,  0);
        check("rw_s_stb_clr", bus.s_stb_o, 0);
        check("rw_ack",   bus.ack_o,   0);
        check("rw_err",   bus.err_o,   0);
        check("rw_dat_o", bus.dat_o,   0);
        check("rw_s_adr", bus.s_adr_o, 0);
        check("rw_s_dat", bus.s_dat_o, 0);
        check("rw_s_we",  bus.s_we_o,  0);

        // New request after reset completes normally
        bus.s_dat_i[8*1 +: 8] = 8'h3C;
        req(1'b0, 8'h13, 8'h00);
        sb.push_back('{is_err: 1'b0, chk_dat: 1'b1, dat: 8'h3C});
        step();
        bus.stb_i = 1'b0;
        check("pr_s_stb", bus.s_stb_o, 12'h002);
        check("pr_s_adr", bus.s_adr_o, 4'h3);
        bus.s_ack_i[1] = 1'b1;
        step();
        bus.s_ack_i = '0;
        check("pr_ack",   bus.ack_o,   1);
        step();
        check("pr_idle",  bus.busy_o,  0);

        step();
        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
